// File: rtl/lsu_data_req.sv
// Load/store initiator for a req/gnt/rvalid data memory port. Optional abort counter: LSU_TIMEOUT_EN.
// Latency: command to done_o is 3 cycles minimum (REQ, RESP, DONE); load data is valid with done_o.
// Backpressure: one command in flight; ready_o is high only in IDLE, and the memory stalls via gnt_i/rvalid_i.
module lsu_data_req #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic                      we_i,
  input  logic [2:0]                funct3_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      ready_o,
  output logic                      done_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      misalign_o,
  output logic                      timeout_o,
  output logic                      req_o,
  output logic                      we_o,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic [TRANSFER_WIDTH-1:0] be_o,
  input  logic                      gnt_i,
  input  logic                      rvalid_i,
  input  logic [DATA_WIDTH-1:0]     rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                f3_q;
  logic [1:0]                off_q;
  logic                      misaligned;
  logic                      accept;
  logic                      abort;
  logic [TRANSFER_WIDTH-1:0] be_d;
  logic [DATA_WIDTH-1:0]     wdata_d;
  logic [DATA_WIDTH-1:0]     load_ext;
  logic [7:0]                lane_b;
  logic [15:0]               lane_h;

  // Alignment check and memory-side encoding of the incoming command (funct3[1:0] gives the size)
  always_comb begin
    misaligned = 1'b0;
    be_d       = '1;
    wdata_d    = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_d    = TRANSFER_WIDTH'(1) << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = addr_i[0];
        be_d       = TRANSFER_WIDTH'(3) << {addr_i[1], 1'b0};
        wdata_d    = {2{wdata_i[15:0]}};
      end
      default: misaligned = |addr_i[1:0];
    endcase
    if (!we_i) begin
      be_d    = '1;
      wdata_d = '0;
    end
  end

  assign accept = (state_q == IDLE) && valid_i && !misaligned;

  // Pick the addressed lane of the returned word and extend it
  always_comb begin
    lane_b   = rdata_i[{off_q, 3'b000} +: 8];
    lane_h   = rdata_i[{off_q[1], 4'b0000} +: 16];
    load_ext = rdata_i;
    case (f3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      default: load_ext = rdata_i;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          timed_out;

  // Cycles spent waiting on the memory for the current command
  always_ff @(posedge clk) begin
    if (rst)                                       cnt_q <= '0;
    else if (accept)                               cnt_q <= '0;
    else if (state_q == REQ || state_q == RESP)    cnt_q <= cnt_q + 1'b1;
  end

  assign timed_out = (state_q == REQ || state_q == RESP) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // One-cycle abort flag, raised the cycle after the limit is hit
  always_ff @(posedge clk) begin
    if (rst) timeout_o <= 1'b0;
    else     timeout_o <= abort;
  end
`else
  logic timed_out;
  logic timeout_unused;
  assign timed_out      = 1'b0;
  assign timeout_unused = ^TIMEOUT_CYCLES;
  assign timeout_o      = 1'b0;
`endif

  // Next-state: handshake progression; a completion in the limit cycle beats the abort
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (gnt_i) state_d = RESP;
      RESP:    if (!we_o || rvalid_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timed_out && state_d != DONE) begin
      state_d = IDLE;
      abort   = 1'b1;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign req_o   = (state_q == REQ);
  assign done_o  = (state_q == DONE);

  // State, captured command, misalign pulse and held load result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      be_o       <= '0;
      misalign_o <= 1'b0;
      rdata_o    <= '0;
    end else begin
      state_q    <= state_d;
      misalign_o <= (state_q == IDLE) && valid_i && misaligned;
      if (accept) begin
        f3_q    <= funct3_i;
        off_q   <= addr_i[1:0];
        we_o    <= we_i;
        addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
        wdata_o <= wdata_d;
        be_o    <= be_d;
      end
      if (state_q == RESP && !we_o && state_d == DONE) rdata_o <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu_data_req.sv
// Bench for lsu_data_req: a timeline model derived from the command/handshake rules sets per-cycle expectations,
// one negedge process compares every output, and directed cases pin the model with literal values.
// The bench acts as the memory responder with random grant/response delays and random noise on ignored inputs.
module tb_lsu_data_req;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0, we_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [9:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_i = 1'b0, rvalid_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic        ready_o, done_o, misalign_o, timeout_o, req_o, we_o;
  logic [31:0] rdata_o, wdata_o;
  logic [9:0]  addr_o;
  logic [3:0]  be_o;

  lsu_data_req dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .done_o(done_o),
    .rdata_o(rdata_o), .misalign_o(misalign_o), .timeout_o(timeout_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-cycle expectations from the model
  bit          armed = 1'b0;
  bit          exp_ready, exp_req, exp_done, exp_mis, exp_bus, exp_chk_wd, exp_we;
  logic [9:0]  exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;
  logic [31:0] model_rdata = '0;

  // Values captured from the DUT only for literal comparisons
  int          cyc, cap_done_cyc;
  bit          cap_seen, cap_mis;
  logic [9:0]  cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        cap_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // The single compare process
  always @(negedge clk) begin
    if (armed) begin
      chk("ready_o", 32'(ready_o), 32'(exp_ready));
      chk("req_o", 32'(req_o), 32'(exp_req));
      chk("done_o", 32'(done_o), 32'(exp_done));
      chk("misalign_o", 32'(misalign_o), 32'(exp_mis));
      chk("timeout_o", 32'(timeout_o), 32'd0);
      chk("rdata_o", rdata_o, model_rdata);
      if (exp_bus) begin
        chk("we_o", 32'(we_o), 32'(exp_we));
        chk("addr_o", 32'(addr_o), 32'(exp_addr));
        chk("be_o", 32'(be_o), 32'(exp_be));
        if (exp_chk_wd) chk("wdata_o", wdata_o, exp_wdata);
      end
    end
  end

  function automatic logic [31:0] ext(input logic [2:0] f3, input int off, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  task automatic set_idle();
    exp_ready = 1'b1; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0; exp_bus = 1'b0;
  endtask

  // Random values on inputs the DUT must ignore in the current cycle
  task automatic noise(input bit allow_valid);
    gnt_i    = 1'($urandom);
    rvalid_i = 1'($urandom);
    rdata_i  = $urandom;
    valid_i  = allow_valid ? 1'($urandom) : 1'b0;
    we_i     = 1'($urandom);
    funct3_i = 3'($urandom);
    addr_i   = 10'($urandom);
    wdata_i  = $urandom;
  endtask

  task automatic tick();
    @(negedge clk);
    if (req_o && !cap_seen) begin
      cap_seen = 1'b1; cap_addr = addr_o; cap_be = be_o; cap_wdata = wdata_o; cap_we = we_o;
    end
    if (done_o) cap_done_cyc = cyc;
    if (misalign_o) cap_mis = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One command from IDLE: gd stall cycles before grant, rd cycles before store response
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [9:0] a, input logic [31:0] wd,
                        input int gd, input int rd, input logic [31:0] mem);
    int sz, off;
    bit mis;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a) % 4;
    mis = (int'(a) % sz) != 0;
    cap_seen = 1'b0; cap_mis = 1'b0; cap_done_cyc = -1; cyc = 0;
    noise(0);
    valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    set_idle();
    tick();
    if (mis) begin
      noise(0); exp_mis = 1'b1; tick();
      noise(0); exp_mis = 1'b0; return;
    end
    exp_ready = 1'b0; exp_bus = 1'b1; exp_we = we; exp_addr = a & 10'h3FC; exp_chk_wd = we;
    exp_be    = !we ? 4'hF : (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << (off & 2)) : 4'hF;
    exp_wdata = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    for (int k = 0; k <= gd; k++) begin
      noise(1); exp_req = 1'b1; gnt_i = (k == gd); tick();
    end
    exp_req = 1'b0;
    if (!we) begin
      noise(1); rdata_i = mem; tick();
    end else begin
      for (int j = 0; j <= rd; j++) begin
        noise(1); rvalid_i = (j == rd); tick();
      end
    end
    noise(1); exp_done = 1'b1;
    if (!we) model_rdata = ext(f3, off, mem);
    tick();
    noise(0); set_idle();
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    set_idle(); exp_bus = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_chk_wd = 1'b1;
    armed = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    set_idle();

    // LW with grant in the second request cycle
    do_txn(1'b0, 3'd2, 10'h010, 32'h0, 1, 0, 32'h8000_00F0);
    chk("lw_addr", 32'(cap_addr), 32'h010);
    chk("lw_be", 32'(cap_be), 32'hF);
    chk("lw_done_cyc", 32'(cap_done_cyc), 32'd4);
    chk("lw_rdata", rdata_o, 32'h8000_00F0);

    do_txn(1'b0, 3'd0, 10'h013, 32'h0, 0, 0, 32'h8A00_0000);
    chk("lb_rdata", rdata_o, 32'hFFFF_FF8A);
    do_txn(1'b0, 3'd4, 10'h013, 32'h0, 2, 0, 32'h8A00_0000);
    chk("lbu_rdata", rdata_o, 32'h0000_008A);
    do_txn(1'b0, 3'd1, 10'h012, 32'h0, 0, 0, 32'h8001_0000);
    chk("lh_rdata", rdata_o, 32'hFFFF_8001);

    // SB with delayed store response; rdata_o must hold the LH result
    do_txn(1'b1, 3'd0, 10'h005, 32'h1234_56AB, 1, 3, 32'h0);
    chk("sb_addr", 32'(cap_addr), 32'h004);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    chk("sb_we", 32'(cap_we), 32'd1);
    chk("sb_done_cyc", 32'(cap_done_cyc), 32'd7);
    chk("sb_hold_rdata", rdata_o, 32'hFFFF_8001);

    // Misaligned commands
    do_txn(1'b1, 3'd1, 10'h003, 32'h5555_AAAA, 0, 0, 32'h0);
    chk("sh_mis_req", 32'(cap_seen), 32'd0);
    chk("sh_mis_pulse", 32'(cap_mis), 32'd1);
    chk("sh_mis_done", 32'(cap_done_cyc), 32'hFFFF_FFFF);
    do_txn(1'b0, 3'd2, 10'h002, 32'h0, 0, 0, 32'h0);
    chk("lw_mis_req", 32'(cap_seen), 32'd0);
    chk("lw_mis_pulse", 32'(cap_mis), 32'd1);

    // Reset while requesting
    noise(0); valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'd2; addr_i = 10'h040; set_idle(); tick();
    noise(1); exp_ready = 1'b0; exp_req = 1'b1; exp_bus = 1'b1; exp_we = 1'b0; exp_addr = 10'h040;
    exp_be = 4'hF; exp_chk_wd = 1'b0; gnt_i = 1'b0; rst = 1'b1; cap_done_cyc = -1; tick();
    rst = 1'b0; noise(0); set_idle(); exp_bus = 1'b1; exp_addr = '0; exp_be = '0; exp_wdata = '0;
    exp_chk_wd = 1'b1; model_rdata = '0; tick();
    chk("rst_no_done", 32'(cap_done_cyc), 32'hFFFF_FFFF);
    set_idle();
    do_txn(1'b0, 3'd2, 10'h100, 32'h0, 1, 0, 32'hCAFE_F00D);
    chk("post_rst_lw", rdata_o, 32'hCAFE_F00D);

    // Randomized commands
    for (int n = 0; n < 120; n++) begin
      do_txn(1'($urandom), 3'($urandom), 10'($urandom), $urandom,
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom);
    end
    tick();

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
